bypass_hazard_unit: RTL

//  Parametrised forwarding and hazard unit for the 5-stage core. Picks the youngest matching producer

---
 rtl/bypass_hazard_unit_if.sv | 33 +++
 rtl/bypass_hazard_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bypass_hazard_unit_if.sv
// Signal bundle between the pipeline control and the bypass/hazard unit.
// master = pipeline side (drives instructions), slave = the unit itself.
interface bypass_hazard_unit_if #(
    parameter int NUM_STAGES = 2
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic [31:0]              dec_ir;
    logic [31:0]              ex_ir;
    logic [32*NUM_STAGES-1:0] src_ir;
    logic [NUM_STAGES-1:0]    src_exc;
    logic                     md_ready;
    logic                     flush;
    logic [SEL_W-1:0]         alu_a_sel;
    logic [SEL_W-1:0]         alu_b_sel;
    logic [SEL_W-1:0]         dmem_sel;
    logic                     stall;
    logic                     md_busy;
    logic [4:0]               md_rd;
    logic                     md_state_dbg;

    // No valid/ready pairing: all inputs are sampled every cycle, selects and stall
    // are combinational, md_busy/md_rd/md_state_dbg are registered.
    modport master (
        output dec_ir, ex_ir, src_ir, src_exc, md_ready, flush,
        input  alu_a_sel, alu_b_sel, dmem_sel, stall, md_busy, md_rd, md_state_dbg
    );

    modport slave (
        input  dec_ir, ex_ir, src_ir, src_exc, md_ready, flush,
        output alu_a_sel, alu_b_sel, dmem_sel, stall, md_busy, md_rd, md_state_dbg
    );
endinterface

// File: rtl/bypass_hazard_unit.sv
// Forwarding select, load-use interlock and multdiv scoreboard for the 5-stage core.
// Optional stall counter output enabled by defining STALL_CNT_EN.
module bypass_hazard_unit #(
    parameter int         NUM_STAGES = 2,
    parameter int         SEL_W      = $clog2(NUM_STAGES + 1),
    parameter logic [4:0] EXC_REG    = 5'd30,
    parameter logic [4:0] LINK_REG   = 5'd31
`ifdef STALL_CNT_EN
    ,
    parameter int         CNT_W      = 16
`endif
) (
    input  logic clock,
    input  logic reset,
    bypass_hazard_unit_if.slave bus
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] d;
    } reads_t;

    function automatic logic [4:0] dest_of(input logic [31:0] ir, input logic exc);
        logic [4:0] d;
        d = 5'd0;
        case (ir[31:27])
            OP_R, OP_ADDI, OP_LW: d = ir[26:22];
            OP_JAL:               d = LINK_REG;
            OP_SETX:              d = EXC_REG;
            default:              d = 5'd0;
        endcase
        if (exc) d = EXC_REG;
        return d;
    endfunction

    // a/b feed the ALU, d is sw store data; unused slots read r0 so they never match.
    function automatic reads_t reads_of(input logic [31:0] ir);
        reads_t r;
        r = '0;
        case (ir[31:27])
            OP_R:          begin r.a = ir[21:17]; r.b = ir[16:12]; end
            OP_ADDI, OP_LW: r.a = ir[21:17];
            OP_SW:         begin r.a = ir[21:17]; r.d = ir[26:22]; end
            OP_BNE, OP_BLT: begin r.a = ir[26:22]; r.b = ir[21:17]; end
            OP_JR:         r.a = ir[26:22];
            OP_BEX:        r.a = EXC_REG;
            default:       r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_md(input logic [31:0] ir);
        return (ir[31:27] == OP_R) && ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
    endfunction

    logic [4:0]       src_dest [NUM_STAGES];
    reads_t           ex_rd;
    reads_t           dec_rd;
    reads_t           mem_rd;
    logic [4:0]       ex_dest;
    logic [4:0]       dec_dest;
    logic [SEL_W-1:0] a_sel;
    logic [SEL_W-1:0] b_sel;
    logic [SEL_W-1:0] d_sel;
    logic             load_use;
    logic             md_start;
    logic             md_hazard;
    logic             md_stall;
    logic             stall;
    md_state_t        state_q, state_d;
    logic [4:0]       md_rd_q, md_rd_d;

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            src_dest[k] = dest_of(bus.src_ir[32*k +: 32], bus.src_exc[k]);
        end
        ex_rd    = reads_of(bus.ex_ir);
        dec_rd   = reads_of(bus.dec_ir);
        mem_rd   = reads_of(bus.src_ir[31:0]);
        ex_dest  = dest_of(bus.ex_ir, 1'b0);
        dec_dest = dest_of(bus.dec_ir, 1'b0);
    end

    // Walk oldest to youngest so the youngest (lowest k) match is written last.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        d_sel = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (ex_rd.a != 5'd0 && src_dest[k] == ex_rd.a) a_sel = SEL_W'(k + 1);
            if (ex_rd.b != 5'd0 && src_dest[k] == ex_rd.b) b_sel = SEL_W'(k + 1);
        end
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (mem_rd.d != 5'd0 && src_dest[k] == mem_rd.d) d_sel = SEL_W'(k + 1);
        end
    end

    always_comb begin
        load_use = (bus.ex_ir[31:27] == OP_LW) && (ex_dest != 5'd0) &&
                   ((ex_dest == dec_rd.a) || (ex_dest == dec_rd.b) || (ex_dest == dec_rd.d));
        md_start = is_md(bus.ex_ir) && (ex_dest != 5'd0) && !bus.flush;
        md_hazard = (dec_rd.a == md_rd_q) || (dec_rd.b == md_rd_q) || (dec_rd.d == md_rd_q) ||
                    (dec_dest == md_rd_q) || is_md(bus.dec_ir);
    end

    // md_ready releases the stall in the same cycle; flush does not cancel a pending op.
    always_comb begin
        state_d  = state_q;
        md_rd_d  = md_rd_q;
        md_stall = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    md_rd_d = ex_dest;
                end
            end
            MD_BUSY: begin
                if (md_hazard && !bus.md_ready) md_stall = 1'b1;
                if (bus.md_ready) begin
                    state_d = MD_IDLE;
                    md_rd_d = 5'd0;
                end
            end
        endcase
        stall = !bus.flush && (load_use || md_stall);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            md_rd_q <= 5'd0;
        end else begin
            state_q <= state_d;
            md_rd_q <= md_rd_d;
        end
    end

    assign bus.alu_a_sel    = a_sel;
    assign bus.alu_b_sel    = b_sel;
    assign bus.dmem_sel     = d_sel;
    assign bus.stall        = stall;
    assign bus.md_busy      = (state_q == MD_BUSY);
    assign bus.md_rd        = md_rd_q;
    assign bus.md_state_dbg = state_q;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}})) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
